gate_input_debounce: RTL and testbench

GATE_INPUT_DEBOUNCE -- requirements
Module: gate_input_debounce

---
 rtl/gate_db_pkg.sv | 16 +
 rtl/db_channel.sv | 81 ++++++++
 rtl/gate_input_debounce.sv | 58 +++++
 tb/tb_gate_input_debounce.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_db_pkg.sv
// Shared constants and helpers for the gate input debouncer.
// Consumed by db_channel and gate_input_debounce.
package gate_db_pkg;

    localparam int unsigned NUM_CH           = 8;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_DEBOUNCE_CNT = 16;

    // Counter width for a stability count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        int unsigned w;
        w = $unsigned($clog2(depth));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce lane: synchronizer chain, stability counter and output flop.
// i_bypass forwards the synchronized level straight to the output flop.
module db_channel
    import gate_db_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ena,
    input  logic i_bypass,
    input  logic i_raw,
    output logic o_db,
    output logic o_flip,
    output logic o_flip_c
);

    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_db;
    logic                   r_flip;

    logic [CW-1:0]          w_cnt_next;
    logic                   w_db_next;
    logic                   w_flip_next;
    logic                   w_upd;
    logic                   w_sync;
    logic                   w_sync_early;

    assign w_sync       = r_sync[SYNC_STAGES-1];
    // Value entering the last stage this edge; lets bypass land on the same edge as sync.
    assign w_sync_early = r_sync[SYNC_STAGES-2];

    always_comb begin
        w_cnt_next  = r_cnt;
        w_db_next   = r_db;
        w_flip_next = r_flip;
        w_upd       = 1'b0;
        if (i_bypass) begin
            w_upd       = 1'b1;
            w_cnt_next  = '0;
            w_db_next   = w_sync_early;
            w_flip_next = w_sync_early ^ r_db;
        end else if (i_ena) begin
            w_upd       = 1'b1;
            w_flip_next = 1'b0;
            if (w_sync == r_db) begin
                w_cnt_next = '0;
            end else if (r_cnt == CNT_MAX) begin
                w_cnt_next  = '0;
                w_db_next   = w_sync;
                w_flip_next = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_flip <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_cnt  <= w_cnt_next;
            r_db   <= w_db_next;
            r_flip <= w_flip_next;
        end
    end

    assign o_db     = r_db;
    assign o_flip   = r_flip;
    assign o_flip_c = w_upd & w_flip_next;

endmodule

// File: rtl/gate_input_debounce.sv
// Eight-lane switch debouncer feeding the quad AND gate stage, with change reporting.
// Optional bypass input enabled by defining GATE_DB_BYPASS_EN.
module gate_input_debounce
    import gate_db_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
`ifdef GATE_DB_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic              change_strobe,
    output logic [NUM_CH-1:0] change_mask
);

    logic              w_bypass;
    logic [NUM_CH-1:0] w_flip_c;
    logic              r_strobe;

`ifdef GATE_DB_BYPASS_EN
    assign w_bypass = bypass;
`else
    assign w_bypass = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        db_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_ena    (ena),
            .i_bypass (w_bypass),
            .i_raw    (raw_in[g]),
            .o_db     (db_out[g]),
            .o_flip   (change_mask[g]),
            .o_flip_c (w_flip_c[g])
        );
    end

    // Strobe registered alongside the per-lane mask flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= |w_flip_c;
        end
    end

    assign change_strobe = r_strobe;

endmodule

// File: tb/tb_gate_input_debounce.sv
// Directed bench for gate_input_debounce at SYNC_STAGES=2, DEBOUNCE_CNT=4.
// Define GATE_DB_BYPASS_EN to also exercise the bypass input.
module tb_gate_input_debounce;

    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic [7:0] change_mask;
    logic       change_strobe;
`ifdef GATE_DB_BYPASS_EN
    logic       bypass;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_input_debounce #(
        .SYNC_STAGES  (SS),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
`ifdef GATE_DB_BYPASS_EN
        .bypass        (bypass),
`endif
        .raw_in        (raw_in),
        .db_out        (db_out),
        .change_strobe (change_strobe),
        .change_mask   (change_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        raw_in = 8'h00;
`ifdef GATE_DB_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        raw_in = 8'hFF;
`ifdef GATE_DB_BYPASS_EN
        bypass = 1'b0;
`endif
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({db_out, change_mask, change_strobe} !== 17'h0) begin
                errors++;
                $display("FAIL reset edge %0d: db=%h mask=%h stb=%b expected all zero",
                         e, db_out, change_mask, change_strobe);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        raw_in = 8'h03;
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_db   = (e >= 6) ? 8'h03 : 8'h00;
            e_mask = (e == 6) ? 8'h03 : 8'h00;
            e_stb  = (e == 6);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL basic_rise edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
        raw_in = 8'h00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_db   = (e >= 6) ? 8'h00 : 8'h03;
            e_mask = (e == 6) ? 8'h03 : 8'h00;
            e_stb  = (e == 6);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL basic_fall edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        raw_in = 8'h01;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) raw_in = 8'h00;
            if (e == 2) raw_in = 8'h01;
            e_db   = (e >= 8) ? 8'h01 : 8'h00;
            e_mask = (e == 8) ? 8'h01 : 8'h00;
            e_stb  = (e == 8);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL bounce edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        raw_in = 8'hFF;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 2)  ena = 1'b0;
            if (e == 10) ena = 1'b1;
            e_db   = (e >= 14) ? 8'hFF : 8'h00;
            e_mask = (e == 14) ? 8'hFF : 8'h00;
            e_stb  = (e == 14);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL enable edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
        // Freeze right after an update: mask holds, strobe drops.
        ena = 1'b0;
        tick();
        checks++;
        if ({db_out, change_mask, change_strobe} !== {8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL enable_hold: db=%h mask=%h stb=%b expected db=ff mask=ff stb=0",
                     db_out, change_mask, change_strobe);
        end
        ena = 1'b1;
        tick();
        checks++;
        if ({db_out, change_mask, change_strobe} !== {8'hFF, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL enable_resume: db=%h mask=%h stb=%b expected db=ff mask=00 stb=0",
                     db_out, change_mask, change_strobe);
        end
    endtask

    task automatic test_reset_midway();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        raw_in = 8'hAA;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3) rst = 1'b1;
            if (e == 4) rst = 1'b0;
            e_db   = (e >= 10) ? 8'hAA : 8'h00;
            e_mask = (e == 10) ? 8'hAA : 8'h00;
            e_stb  = (e == 10);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL reset_midway edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        raw_in = 8'h01;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 2) raw_in = 8'h03;
            e_db   = (e >= 8) ? 8'h03 : ((e >= 6) ? 8'h01 : 8'h00);
            e_mask = (e == 6) ? 8'h01 : ((e == 8) ? 8'h02 : 8'h00);
            e_stb  = (e == 6) || (e == 8);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL back_to_back edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
    endtask

`ifdef GATE_DB_BYPASS_EN
    task automatic test_bypass();
        logic [7:0] e_db, e_mask;
        logic       e_stb;
        apply_reset();
        bypass = 1'b1;
        raw_in = 8'h5A;
        for (int e = 1; e <= 4; e++) begin
            tick();
            e_db   = (e >= 2) ? 8'h5A : 8'h00;
            e_mask = (e == 2) ? 8'h5A : 8'h00;
            e_stb  = (e == 2);
            checks++;
            if ({db_out, change_mask, change_strobe} !== {e_db, e_mask, e_stb}) begin
                errors++;
                $display("FAIL bypass edge %0d: db=%h mask=%h stb=%b expected db=%h mask=%h stb=%b",
                         e, db_out, change_mask, change_strobe, e_db, e_mask, e_stb);
            end
        end
        bypass = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_enable();
        test_reset_midway();
        test_back_to_back();
`ifdef GATE_DB_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
